wolfram_ca_engine: RTL and testbench

//  Parametrised successor to the fixed 3-input truth-table gates: a WIDTH-cell, 1-D elementary cellular automaton.

---
 rtl/wolfram_ca_pkg.sv | 16 +
 rtl/wolfram_ca_cell.sv | 12 +
 rtl/wolfram_ca_engine.sv | 107 ++++++++++
 tb/tb_wolfram_ca_engine.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/wolfram_ca_pkg.sv
// wolfram_ca_pkg: shared FSM states, rule width and rule-table lookup for the CA engine.
package wolfram_ca_pkg;
  localparam int RULE_W = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_e;
  // Row 000 of the truth table lives in bit 7, so the neighbourhood indexes from the MSB.
  function automatic logic rule_lookup(input logic [RULE_W-1:0] rule, input logic [2:0] k);
    return rule[3'd7 - k];
  endfunction
endpackage

// File: rtl/wolfram_ca_cell.sv
// wolfram_ca_cell: combinational next-state of one cell from its 3-cell neighbourhood.
module wolfram_ca_cell
  import wolfram_ca_pkg::*;
(
  input  logic [RULE_W-1:0] rule,
  input  logic              hi,
  input  logic              mid,
  input  logic              lo,
  output logic              next
);
  assign next = rule_lookup(rule, {hi, mid, lo});
endmodule

// File: rtl/wolfram_ca_engine.sv
// wolfram_ca_engine: WIDTH-cell elementary cellular automaton with start/done handshake.
// Optional early stop on a fixed point when CA_FIXPOINT_EN is defined.
module wolfram_ca_engine
  import wolfram_ca_pkg::*;
#(
  parameter int                WIDTH     = 16,
  parameter logic [RULE_W-1:0] RULE_INIT = 8'h74,
  parameter int                BOUNDARY  = 0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              rule_we,
  input  logic [RULE_W-1:0] rule_wdata,
  input  logic              step_valid,
  output logic              step_ready,
  input  logic [CNT_W-1:0]  step_count,
  output logic              busy,
  output logic              done,
  output logic              fixpoint,
  output logic [CNT_W-1:0]  gen_count,
  output logic [WIDTH-1:0]  state_out
);
  state_e            fsm;
  logic [RULE_W-1:0] rule;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  gen_inc;
  logic [WIDTH-1:0]  nxt;

  assign load_ready = fsm == IDLE;
  assign step_ready = fsm == IDLE;
  assign busy       = fsm == RUN;
  assign done       = fsm == DONE;
  assign gen_inc    = gen_count + 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic hi, lo;
    if (i == WIDTH - 1) begin : g_hi_edge
      assign hi = (BOUNDARY != 0) ? 1'b0 : state_out[0];
    end else begin : g_hi
      assign hi = state_out[i+1];
    end
    if (i == 0) begin : g_lo_edge
      assign lo = (BOUNDARY != 0) ? 1'b0 : state_out[WIDTH-1];
    end else begin : g_lo
      assign lo = state_out[i-1];
    end
    wolfram_ca_cell u_cell (
      .rule (rule),
      .hi   (hi),
      .mid  (state_out[i]),
      .lo   (lo),
      .next (nxt[i])
    );
  end

`ifndef CA_FIXPOINT_EN
  assign fixpoint = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state_out <= '0;
      rule      <= RULE_INIT;
      gen_count <= '0;
      target    <= '0;
`ifdef CA_FIXPOINT_EN
      fixpoint  <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (load_valid) state_out <= load_data;
          if (rule_we) rule <= rule_wdata;
          if (step_valid) begin
            gen_count <= '0;
            target    <= step_count;
            fsm       <= (step_count == '0) ? DONE : RUN;
`ifdef CA_FIXPOINT_EN
            fixpoint  <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifdef CA_FIXPOINT_EN
          if (nxt == state_out) begin
            fixpoint <= 1'b1;
            fsm      <= DONE;
          end else begin
`else
          begin
`endif
            state_out <= nxt;
            gen_count <= gen_inc;
            if (gen_inc == target) fsm <= DONE;
          end
        end
        DONE:    fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wolfram_ca_engine.sv
// tb_wolfram_ca_engine: periodic and null-boundary engines driven in lockstep against a behavioural model.
module tb_wolfram_ca_engine;
`ifdef CA_FIXPOINT_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0, rule_we = 1'b0, step_valid = 1'b0;
  logic [7:0]  load_data = '0, rule_wdata = '0;
  logic [15:0] step_count = '0;
  logic        load_ready_p, step_ready_p, busy_p, done_p, fix_p;
  logic        load_ready_n, step_ready_n, busy_n, done_n, fix_n;
  logic [15:0] gen_p, gen_n;
  logic [7:0]  st_p, st_n;
  int          vectors = 0, miscompares = 0;
  logic [7:0]  cur_rule = 8'h74;

  always #5 clk = ~clk;

  wolfram_ca_engine #(.WIDTH(8), .RULE_INIT(8'h74), .BOUNDARY(0), .CNT_W(16)) dut_p (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_p),
    .load_data(load_data), .rule_we(rule_we), .rule_wdata(rule_wdata),
    .step_valid(step_valid), .step_ready(step_ready_p), .step_count(step_count),
    .busy(busy_p), .done(done_p), .fixpoint(fix_p), .gen_count(gen_p), .state_out(st_p));

  wolfram_ca_engine #(.WIDTH(8), .RULE_INIT(8'h74), .BOUNDARY(1), .CNT_W(16)) dut_n (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_n),
    .load_data(load_data), .rule_we(rule_we), .rule_wdata(rule_wdata),
    .step_valid(step_valid), .step_ready(step_ready_n), .step_count(step_count),
    .busy(busy_n), .done(done_n), .fixpoint(fix_n), .gen_count(gen_n), .state_out(st_n));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ca_next(input logic [7:0] s, input logic [7:0] r, input bit nb);
    logic [7:0] n;
    for (int i = 0; i < 8; i++) begin
      int up = (nb && i == 7) ? 0 : int'(s[(i + 1) % 8]);
      int dn = (nb && i == 0) ? 0 : int'(s[(i + 7) % 8]);
      int k = up * 4 + int'(s[i]) * 2 + dn;
      n[i] = r[7 - k];
    end
    return n;
  endfunction

  task automatic model_run(input logic [7:0] s0, input logic [7:0] r, input int n, input bit nb,
                           output logic [7:0] s, output int g, output int lat, output bit fx);
    logic [7:0] nx;
    s = s0; g = 0; fx = 1'b0;
    while (g < n) begin
      nx = ca_next(s, r, nb);
      if (FIX && nx == s) begin fx = 1'b1; break; end
      s = nx;
      g++;
    end
    lat = (n == 0) ? 1 : fx ? g + 2 : n + 1;
  endtask

  task automatic start(input logic [7:0] ld, input bit wr, input logic [7:0] rl, input int n);
    @(negedge clk);
    load_valid = 1'b1; load_data = ld; rule_we = wr; rule_wdata = rl;
    step_valid = 1'b1; step_count = n[15:0];
    @(negedge clk);
    load_valid = 1'b0; rule_we = 1'b0; step_valid = 1'b0;
  endtask

  task automatic finish(input string tag, input int c0, input int elp, input int eln,
                        input logic [7:0] esp, input logic [7:0] esn, input int egp, input int egn,
                        input bit efp, input bit efn);
    int lp = 0, ln = 0;
    for (int c = c0; c <= c0 + elp + eln + 8; c++) begin
      if (done_p && lp == 0) lp = c;
      if (done_n && ln == 0) ln = c;
      if (lp != 0 && ln != 0) break;
      @(negedge clk);
    end
    check({tag, "_lat_p"}, lp, elp);
    check({tag, "_lat_n"}, ln, eln);
    check({tag, "_st_p"}, {24'h0, st_p}, {24'h0, esp});
    check({tag, "_st_n"}, {24'h0, st_n}, {24'h0, esn});
    check({tag, "_gen_p"}, {16'h0, gen_p}, egp);
    check({tag, "_gen_n"}, {16'h0, gen_n}, egn);
    check({tag, "_fix_p"}, {31'h0, fix_p}, {31'h0, efp});
    check({tag, "_fix_n"}, {31'h0, fix_n}, {31'h0, efn});
  endtask

  task automatic do_run(input string tag, input logic [7:0] ld, input bit wr, input logic [7:0] rl, input int n);
    logic [7:0] sp, sn;
    int gp, gn, lp, ln;
    bit fp, fn;
    if (wr) cur_rule = rl;
    model_run(ld, cur_rule, n, 1'b0, sp, gp, lp, fp);
    model_run(ld, cur_rule, n, 1'b1, sn, gn, ln, fn);
    start(ld, wr, rl, n);
    finish(tag, 1, lp, ln, sp, sn, gp, gn, fp, fn);
  endtask

  typedef struct {
    logic [7:0] ld, rl;
    int n;
    logic [7:0] ep, en;
    int gp, gn, lat;
    bit fxp, fxn;
  } vec_t;
  vec_t tbl[5];

  initial begin
    bit saw;
    tbl[0] = '{8'h10, 8'h74, 1, 8'h30, 8'h30, 1, 1, 2, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 8'h74, 1, 8'h03, 8'h03, 1, 1, 2, 1'b0, 1'b0};
    tbl[2] = '{8'h80, 8'h74, 1, 8'h81, 8'h80, 1, FIX ? 0 : 1, 2, 1'b0, FIX};
    tbl[3] = '{8'h5A, 8'h74, 0, 8'h5A, 8'h5A, 0, 0, 1, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 8'hFF, 2, 8'hFF, 8'hFF, FIX ? 1 : 2, FIX ? 1 : 2, 3, FIX, FIX};

    #1;
    check("rst_state", {24'h0, st_p}, 32'h0);
    check("rst_gen", {16'h0, gen_p}, 32'h0);
    check("rst_flags", {busy_p, done_p, fix_p, busy_n, done_n, fix_n}, 32'h0);
    check("rst_ready", {load_ready_p, step_ready_p, load_ready_n, step_ready_n}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // RULE_INIT must already be in effect without any rule write.
    start(8'h10, 1'b0, 8'h00, 1);
    finish("init_rule", 1, 2, 2, 8'h30, 8'h30, 1, 1, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      cur_rule = tbl[i].rl;
      start(tbl[i].ld, 1'b1, tbl[i].rl, tbl[i].n);
      finish($sformatf("tbl%0d", i), 1, tbl[i].lat, tbl[i].lat, tbl[i].ep, tbl[i].en,
             tbl[i].gp, tbl[i].gn, tbl[i].fxp, tbl[i].fxn);
    end

    for (int k = 0; k < 8; k++)
      do_run($sformatf("row%0d", k), 8'($urandom), 1'b1, 8'h80 >> k, 1);

    start(8'h00, 1'b1, 8'h74, 10);
    cur_rule = 8'h74;
    finish("fixpt", 1, FIX ? 2 : 11, FIX ? 2 : 11, 8'h00, 8'h00, FIX ? 0 : 10, FIX ? 0 : 10, FIX, FIX);

    for (int r = 0; r < 20; r++)
      do_run($sformatf("rand%0d", r), 8'($urandom), 1'b1, 8'($urandom), int'($urandom_range(0, 20)));

    // Requests during RUN must be ignored; rule 0x0F rotates the ring.
    begin
      logic [7:0] sp, sn;
      int gp, gn, lp, ln;
      bit fp, fn;
      cur_rule = 8'h0F;
      model_run(8'h10, 8'h0F, 10, 1'b0, sp, gp, lp, fp);
      model_run(8'h10, 8'h0F, 10, 1'b1, sn, gn, ln, fn);
      start(8'h10, 1'b1, 8'h0F, 10);
      check("run_busy", {busy_p, busy_n}, 32'h3);
      check("run_ready", {load_ready_p, step_ready_p}, 32'h0);
      load_valid = 1'b1; load_data = 8'hFF; rule_we = 1'b1; rule_wdata = 8'h00;
      step_valid = 1'b1; step_count = 16'd1;
      @(negedge clk);
      load_valid = 1'b0; rule_we = 1'b0; step_valid = 1'b0;
      finish("ignore", 2, lp, ln, sp, sn, gp, gn, fp, fn);
    end
    do_run("rule_kept", 8'h21, 1'b0, 8'h00, 3);

    do_run("sat", 8'h10, 1'b1, 8'h0F, 65535);
    repeat (3) @(negedge clk);
    check("sat_hold", {16'h0, gen_p}, 32'hFFFF);

    // Asynchronous reset partway through a run: back to reset values, no done pulse.
    start(8'h10, 1'b1, 8'h0F, 10);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_state", {st_p, st_n}, 32'h0);
    check("mrst_gen", {gen_p, gen_n}, 32'h0);
    check("mrst_flags", {busy_p, done_p, fix_p, busy_n, done_n, fix_n}, 32'h0);
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done_p || done_n || busy_p || busy_n) saw = 1'b1;
    end
    check("mrst_quiet", {31'h0, saw}, 32'h0);
    rst_n = 1'b1;
    cur_rule = 8'h74;
    start(8'h10, 1'b0, 8'h00, 1);
    finish("mrst_rule", 1, 2, 2, 8'h30, 8'h30, 1, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
